// File: rtl/stream_demux2_rtl.sv
// stream_demux2_rtl: 1-to-2 val/rdy stream demultiplexer.
// Each output owns a two-entry registered queue, so one stalled consumer
// never blocks traffic headed for the other. in_rdy comes only from in_sel
// and registered queue state, so there is no combinational rdy path.
// Optional feature macro: STREAM_DEMUX2_COUNT_EN adds out0_count and
// out1_count, 16-bit wrapping counts of messages dequeued per output.
//
// Queue state | meaning
// S_EMPTY     | no entries, outk_val=0, outk_msg holds its last value
// S_ONE       | head valid
// S_TWO       | head and tail valid, queue full
module stream_demux2_rtl #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_sel,
  input  logic [NBITS-1:0] in_msg,
  output logic             out0_val,
  input  logic             out0_rdy,
  output logic [NBITS-1:0] out0_msg,
  output logic             out1_val,
  input  logic             out1_rdy,
  output logic [NBITS-1:0] out1_msg
`ifdef STREAM_DEMUX2_COUNT_EN
  ,
  output logic [15:0]      out0_count,
  output logic [15:0]      out1_count
`endif
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q [2];
  logic [1:0]       state_d [2];
  logic [NBITS-1:0] head_q  [2];
  logic [NBITS-1:0] head_d  [2];
  logic [NBITS-1:0] tail_q  [2];
  logic [NBITS-1:0] tail_d  [2];

  logic [1:0] enq;
  logic [1:0] deq;
  logic [1:0] out_val;
  logic [1:0] out_rdy;

  // Full state alone decides readiness; a same-cycle dequeue does not bypass.
  assign in_rdy     = in_sel ? (state_q[1] != S_TWO) : (state_q[0] != S_TWO);
  assign out_val[0] = (state_q[0] != S_EMPTY);
  assign out_val[1] = (state_q[1] != S_EMPTY);
  assign out_rdy    = {out1_rdy, out0_rdy};
  assign enq        = {in_sel, ~in_sel} & {2{in_val & in_rdy}};
  assign deq        = out_val & out_rdy;

  assign out0_val = out_val[0];
  assign out1_val = out_val[1];
  assign out0_msg = head_q[0];
  assign out1_msg = head_q[1];

  // Next-state for each independent queue.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k] = state_q[k];
      head_d[k]  = head_q[k];
      tail_d[k]  = tail_q[k];
      case (state_q[k])
        S_EMPTY: begin
          if (enq[k]) begin
            state_d[k] = S_ONE;
            head_d[k]  = in_msg;
          end
        end
        S_ONE: begin
          if (enq[k] && deq[k]) begin
            head_d[k] = in_msg;
          end else if (enq[k]) begin
            state_d[k] = S_TWO;
            tail_d[k]  = in_msg;
          end else if (deq[k]) begin
            state_d[k] = S_EMPTY;
          end
        end
        S_TWO: begin
          if (deq[k]) begin
            state_d[k] = S_ONE;
            head_d[k]  = tail_q[k];
          end
        end
        default: state_d[k] = S_EMPTY;
      endcase
    end
  end

  // Queue registers; reset discards everything and zeroes the heads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= S_EMPTY;
        head_q[k]  <= '0;
        tail_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        head_q[k]  <= head_d[k];
        tail_q[k]  <= tail_d[k];
      end
    end
  end

`ifdef STREAM_DEMUX2_COUNT_EN
  logic [15:0] cnt_q [2];

  // Per-output dequeue counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (deq[k]) cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  assign out0_count = cnt_q[0];
  assign out1_count = cnt_q[1];
`endif

endmodule

// File: tb/tb_stream_demux2_rtl.sv
// Directed bench for stream_demux2_rtl: reset, a vector table, and a few
// hand-written multi-cycle sequences (streaming, counters).
module tb_stream_demux2_rtl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_val;
  logic       in_rdy;
  logic       in_sel;
  logic [7:0] in_msg;
  logic       out0_val;
  logic       out0_rdy;
  logic [7:0] out0_msg;
  logic       out1_val;
  logic       out1_rdy;
  logic [7:0] out1_msg;
`ifdef STREAM_DEMUX2_COUNT_EN
  logic [15:0] out0_count;
  logic [15:0] out1_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  stream_demux2_rtl #(.NBITS(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_sel   (in_sel),
    .in_msg   (in_msg),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg)
`ifdef STREAM_DEMUX2_COUNT_EN
    ,
    .out0_count (out0_count),
    .out1_count (out1_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       val;
    logic       sel;
    logic [7:0] msg;
    logic       r0;
    logic       r1;
    logic       e_rdy;
    logic       e_v0;
    logic [7:0] e_m0;
    logic       e_v1;
    logic [7:0] e_m1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic s, input logic [7:0] m,
                     input logic r0, input logic r1, input logic er,
                     input logic ev0, input logic [7:0] em0,
                     input logic ev1, input logic [7:0] em1);
    vec_t t;
    t.val = v; t.sel = s; t.msg = m; t.r0 = r0; t.r1 = r1;
    t.e_rdy = er; t.e_v0 = ev0; t.e_m0 = em0; t.e_v1 = ev1; t.e_m1 = em1;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0] sb0[$];
  logic [7:0] sb1[$];

  initial begin
    reset_n  = 1'b0;
    in_val   = 1'b0;
    in_sel   = 1'b0;
    in_msg   = 8'h00;
    out0_rdy = 1'b0;
    out1_rdy = 1'b0;

    // Vector table: inputs for one cycle, expected outputs in that cycle.
    //   val   sel   msg     r0    r1    rdy   v0    m0      v1    m1
    add(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    add(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h3C);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h3C);
    add(1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h3C);
    add(1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h3C);
    add(1'b1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h3C);
    add(1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h3C);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 8'h10);
    add(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 8'h10);
    add(1'b1, 1'b0, 8'h04, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 8'h10);
    add(1'b1, 1'b0, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 8'h10);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 8'h10);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04, 1'b0, 8'h10);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 8'h10);
    add(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 8'h10);
    add(1'b1, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 8'h55);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b1, 8'h66);
    add(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h04, 1'b0, 8'h66);

    // Reset with data queued: outputs clear asynchronously.
    @(negedge clk);
    reset_n = 1'b1;
    in_val = 1'b1; in_sel = 1'b0; in_msg = 8'h77;
    @(negedge clk);
    in_sel = 1'b1; in_msg = 8'h88;
    @(negedge clk);
    in_val = 1'b0;
    #1;
    check("preload_vals", {30'd0, out0_val, out1_val}, 32'd3);
    check("preload_msgs", {16'd0, out0_msg, out1_msg}, 32'h7788);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_reset", {14'd0, out0_val, out1_val, out0_msg, out1_msg}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    in_sel = 1'b0;
    #1;
    check("idle_rdy_sel0", {31'd0, in_rdy}, 32'd1);
    in_sel = 1'b1;
    #1;
    check("idle_rdy_sel1", {31'd0, in_rdy}, 32'd1);

    // Table-driven section.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_val = vecs[i].val; in_sel = vecs[i].sel; in_msg = vecs[i].msg;
      out0_rdy = vecs[i].r0; out1_rdy = vecs[i].r1;
      #1;
      n_vec++;
      if ({in_rdy, out0_val, out0_msg, out1_val, out1_msg} !==
          {vecs[i].e_rdy, vecs[i].e_v0, vecs[i].e_m0, vecs[i].e_v1, vecs[i].e_m1}) begin
        n_err++;
        $display("FAIL vec%0d: got rdy=%b v0=%b m0=%h v1=%b m1=%h expected rdy=%b v0=%b m0=%h v1=%b m1=%h",
                 i, in_rdy, out0_val, out0_msg, out1_val, out1_msg,
                 vecs[i].e_rdy, vecs[i].e_v0, vecs[i].e_m0, vecs[i].e_v1, vecs[i].e_m1);
      end
    end

    // Streaming: random sel/msg each cycle, consumers always ready.
    out0_rdy = 1'b1; out1_rdy = 1'b1;
    for (int i = 0; i < 102; i++) begin
      @(negedge clk);
      in_val = (i < 100);
      in_sel = 1'($urandom_range(0, 1));
      in_msg = 8'($urandom_range(0, 255));
      #1;
      if (in_val) check("stream_rdy", {31'd0, in_rdy}, 32'd1);
      check("stream_v0", {31'd0, out0_val}, {31'd0, sb0.size() != 0});
      check("stream_v1", {31'd0, out1_val}, {31'd0, sb1.size() != 0});
      if (out0_val && sb0.size() != 0) begin
        check("stream_m0", {24'd0, out0_msg}, {24'd0, sb0[0]});
        void'(sb0.pop_front());
      end
      if (out1_val && sb1.size() != 0) begin
        check("stream_m1", {24'd0, out1_msg}, {24'd0, sb1[0]});
        void'(sb1.pop_front());
      end
      if (in_val && in_rdy) begin
        if (in_sel) sb1.push_back(in_msg);
        else sb0.push_back(in_msg);
      end
    end
    check("stream_drained", {30'd0, out0_val, out1_val}, 32'd0);

`ifdef STREAM_DEMUX2_COUNT_EN
    // Counter wrap: 65537 dequeues on out1 leave out1_count at 1.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("cnt_after_reset_a", {out0_count, out1_count}, 32'd0);
    for (int i = 0; i < 65539; i++) begin
      @(negedge clk);
      in_val = (i < 65537);
      in_sel = 1'b1;
      in_msg = 8'(i);
    end
    #1;
    check("cnt_wrap_out1", {16'd0, out1_count}, 32'd1);
    check("cnt_out0_unchanged", {16'd0, out0_count}, 32'd0);
    in_val = 1'b1; in_sel = 1'b0;
    @(negedge clk);
    in_val = 1'b0;
    @(negedge clk);
    #1;
    check("cnt_out0_one", {out0_count, out1_count}, {16'd1, 16'd1});
    reset_n = 1'b0;
    #1;
    check("cnt_after_reset_b", {out0_count, out1_count}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demux2_rtl.md
Name: stream_demux2_rtl

Overview:
- Latency-insensitive 1-to-2 stream demultiplexer.
- Routes each input message to output 0 or output 1, chosen by a per-message select bit.
- Uses val/rdy handshakes on all ports.
- Each output has a two-entry registered queue, so a stalled output does not stall traffic bound for the other output.
- Sits downstream of a producer that fans out to two consumers, as the inverse of the two-input mux.

Parameters:
- NBITS, 8, width of the message payload in bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_val  input  1  input message valid.
- in_rdy  output  1  input ready; transfer occurs when in_val && in_rdy at a rising edge.
- in_sel  input  1  destination of the current input message (0 = out0, 1 = out1); sampled only when in_val=1.
- in_msg  input  NBITS  input payload.
- out0_val  output  1  output 0 valid.
- out0_rdy  input  1  output 0 ready.
- out0_msg  output  NBITS  output 0 payload.
- out1_val  output  1  output 1 valid.
- out1_rdy  input  1  output 1 ready.
- out1_msg  output  NBITS  output 1 payload.

Behaviour:
- Reset: reset_n=0 asynchronously clears both queues.
  - out0_val=0, out1_val=0, out0_msg=0, out1_msg=0.
  - in_rdy=1 once in_val is evaluated against empty queues.
- Reset asserted mid-operation discards all queued messages immediately, without waiting for a clock edge.
- Per-output queue FSM, states EMPTY, ONE, TWO; the two queues are independent.
  - EMPTY: enq -> ONE.
  - ONE: enq only -> TWO; deq only -> EMPTY; enq and deq together -> ONE, with the new entry replacing the head.
  - TWO: deq -> ONE (the second entry moves to the head); enq is impossible because the queue is full.
- Enqueue to queue k: in_val && in_rdy && in_sel==k.
- Dequeue from queue k: outk_val && outk_rdy.
- in_rdy = (in_sel==0) ? (q0 != TWO) : (q1 != TWO).
  - Depends only on in_sel and registered state; never on outk_rdy, so there is no combinational rdy path.
  - A queue in TWO with a same-cycle dequeue still reports full; there is no bypass.
- outk_val=1 iff queue k is not EMPTY.
- outk_msg is the head entry, driven from registers.
- outk_msg holds its last value when the queue is EMPTY; it is 0 after reset.
- Latency: a message accepted at edge N is visible on outk_val/outk_msg after edge N, i.e. in cycle N+1. There is no same-cycle pass-through.
- Ordering: messages to the same output leave in acceptance order. There is no ordering guarantee between out0 and out1.
- Throughput: one message per cycle sustained to either output while that output's consumer keeps outk_rdy=1.
- in_sel and in_msg are don't-care when in_val=0; in_rdy may toggle with in_sel in that case.
- The producer must hold in_val, in_sel and in_msg stable until the transfer occurs.
- outk_val, once asserted, stays asserted with a stable outk_msg until a dequeue.

Optional Feature:
- Macro: STREAM_DEMUX2_COUNT_EN.
- When defined, adds two ports:
  - out0_count  output  16  messages dequeued from out0 since reset.
  - out1_count  output  16  messages dequeued from out1 since reset.
- Each counter:
  - increments by 1 on each dequeue from its output;
  - wraps from 16'hFFFF to 0;
  - clears to 0 on reset_n=0.
- When not defined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset then idle: reset_n=0 with both queues holding data -> out0_val=out1_val=0 and out0_msg=out1_msg=0 immediately; after release, in_rdy=1 for both in_sel values.
- Basic routing: send 8'hA5 with sel=0, then 8'h3C with sel=1, both outk_rdy=1 -> out0 shows 8'hA5 one cycle after its acceptance and out1 shows 8'h3C one cycle after its acceptance; each outk_val pulses for exactly one cycle.
- Backpressure isolation: out0_rdy=0, send 8'h01 and 8'h02 to out0 -> in_rdy=0 for sel=0 but 1 for sel=1; 8'h10 to out1 is accepted and delivered; releasing out0_rdy yields 8'h01 then 8'h02 in order.
- Full with simultaneous dequeue: q0 in TWO, raise out0_rdy while offering sel=0 -> in_rdy stays 0 that cycle and the input is accepted the next cycle.
- Streaming: 100 random messages with random sel and both rdy=1 -> every message is accepted one per cycle and per-output order matches a scoreboard.
- Counter (STREAM_DEMUX2_COUNT_EN): preload via 65537 dequeues on out1 -> out1_count=1 (wrapped) and out0_count unchanged; after reset both read 0.
